// File: rtl/mux_nto1_reg.sv
// N-to-1 handshake mux with a registered output stage, fixed or round-robin
// channel selection, and a running count of completed output transfers.
module mux_nto1_reg #(
  parameter int NB_DATA = 32,
  parameter int N_CH    = 4,
  parameter int NB_SEL  = 2,
  parameter int NB_CNT  = 16
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [N_CH*NB_DATA-1:0] i_data,
  input  logic [N_CH-1:0]         i_valid,
  output logic [N_CH-1:0]         o_ready,
  input  logic [NB_SEL-1:0]       i_sel,
  input  logic                    i_mode,
  output logic [NB_DATA-1:0]      o_data,
  output logic [NB_SEL-1:0]       o_ch,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [NB_CNT-1:0]       o_xfer_cnt
);

  logic [NB_DATA-1:0] ch_data [N_CH];
  logic [NB_SEL-1:0]  rr_ptr;
  logic [NB_SEL-1:0]  grant_idx;
  logic               grant_vld;
  logic               load_en;

  for (genvar k = 0; k < N_CH; k++) begin : g_unpack
    assign ch_data[k] = i_data[k*NB_DATA +: NB_DATA];
  end

  assign load_en = !o_valid || i_ready;

  // Grant search: fixed mode decodes i_sel (out-of-range never matches),
  // round-robin scans upward from rr_ptr and takes the first valid channel.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    if (i_mode) begin
      for (int off = 0; off < N_CH; off++) begin
        if (!grant_vld && i_valid[(int'(rr_ptr) + off) % N_CH]) begin
          grant_vld = 1'b1;
          grant_idx = NB_SEL'((int'(rr_ptr) + off) % N_CH);
        end
      end
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        if (int'(i_sel) == k && i_valid[k]) begin
          grant_vld = 1'b1;
          grant_idx = NB_SEL'(k);
        end
      end
    end
  end

  always_comb begin
    o_ready = '0;
    for (int k = 0; k < N_CH; k++)
      o_ready[k] = !i_reset && load_en && grant_vld && (grant_idx == NB_SEL'(k));
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_valid    <= 1'b0;
      o_data     <= '0;
      o_ch       <= '0;
      rr_ptr     <= '0;
      o_xfer_cnt <= '0;
    end else begin
      if (o_valid && i_ready)
        o_xfer_cnt <= o_xfer_cnt + 1'b1;
      if (load_en) begin
        if (grant_vld) begin
          o_data  <= ch_data[grant_idx];
          o_ch    <= grant_idx;
          o_valid <= 1'b1;
          if (i_mode)
            rr_ptr <= (grant_idx == NB_SEL'(N_CH-1)) ? '0 : grant_idx + 1'b1;
        end else begin
          o_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mux_nto1_reg.sv
// Directed bench for mux_nto1_reg: fixed select, round-robin order/skip/wrap,
// stall hold and mid-operation reset.
module tb_mux_nto1_reg;
  localparam int NB_DATA = 32;
  localparam int N_CH    = 4;
  localparam int NB_SEL  = 2;
  localparam int NB_CNT  = 16;

  logic                    i_clk = 1'b0;
  logic                    i_reset;
  logic [N_CH*NB_DATA-1:0] i_data;
  logic [N_CH-1:0]         i_valid;
  logic [N_CH-1:0]         o_ready;
  logic [NB_SEL-1:0]       i_sel;
  logic                    i_mode;
  logic [NB_DATA-1:0]      o_data;
  logic [NB_SEL-1:0]       o_ch;
  logic                    o_valid;
  logic                    i_ready;
  logic [NB_CNT-1:0]       o_xfer_cnt;

  int n_run = 0;
  int n_fail = 0;

  mux_nto1_reg #(.NB_DATA(NB_DATA), .N_CH(N_CH), .NB_SEL(NB_SEL), .NB_CNT(NB_CNT)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_data(i_data), .i_valid(i_valid),
    .o_ready(o_ready), .i_sel(i_sel), .i_mode(i_mode), .o_data(o_data),
    .o_ch(o_ch), .o_valid(o_valid), .i_ready(i_ready), .o_xfer_cnt(o_xfer_cnt)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_ch(input int k, input logic [NB_DATA-1:0] v);
    i_data[k*NB_DATA +: NB_DATA] = v;
  endtask

  initial begin
    i_reset = 1'b1; i_data = '0; i_valid = 4'b1111; i_sel = '0;
    i_mode = 1'b1; i_ready = 1'b1;
    #1;
    check("ready_in_reset", o_ready, 4'b0000);
    tick();
    check("rst_valid", o_valid, 0);
    check("rst_data", o_data, 0);
    check("rst_ch", o_ch, 0);
    check("rst_cnt", o_xfer_cnt, 0);

    // fixed select of ch2
    i_reset = 1'b0; i_mode = 1'b0; i_sel = 2'd2; i_valid = 4'b0100;
    set_ch(2, 32'hCAFE0002);
    #1;
    check("fix_ready", o_ready, 4'b0100);
    tick();
    check("fix_data", o_data, 32'hCAFE0002);
    check("fix_ch", o_ch, 2);
    check("fix_valid", o_valid, 1);

    // select points at an idle channel: nothing granted, word drains
    i_sel = 2'd1;
    #1;
    check("badsel_ready", o_ready, 4'b0000);
    tick();
    check("badsel_valid", o_valid, 0);
    check("badsel_hold", o_data, 32'hCAFE0002);
    check("badsel_cnt", o_xfer_cnt, 1);

    // round-robin fairness from a fresh reset
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0; i_mode = 1'b1; i_valid = 4'b1111;
    for (int k = 0; k < N_CH; k++) set_ch(k, 32'hA0 + k);
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("rr_ready%0d", i), o_ready, 4'b0001 << (i % 4));
      tick();
      check($sformatf("rr_ch%0d", i), o_ch, i % 4);
      check($sformatf("rr_data%0d", i), o_data, 32'hA0 + (i % 4));
    end
    i_valid = 4'b0000;
    tick();
    check("rr_cnt", o_xfer_cnt, 5);
    check("rr_drained", o_valid, 0);

    // stall: load 0x11 from ch1 in fixed mode, then hold i_ready low
    i_mode = 1'b0; i_sel = 2'd1; i_valid = 4'b0010; set_ch(1, 32'h11);
    tick();
    check("stall_load", o_data, 32'h11);
    i_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_ch(1, 32'h20 + i);
      #1;
      check($sformatf("stall_ready%0d", i), o_ready, 4'b0000);
      tick();
      check($sformatf("stall_data%0d", i), o_data, 32'h11);
      check($sformatf("stall_valid%0d", i), o_valid, 1);
      check($sformatf("stall_cnt%0d", i), o_xfer_cnt, 5);
    end

    // rr_ptr is still 1 (fixed mode left it alone): grant ch2 -> rr_ptr=3
    i_ready = 1'b1; i_mode = 1'b1; i_valid = 4'b0100;
    #1;
    check("rr_from1", o_ready, 4'b0100);
    tick();
    check("rr_ch2", o_ch, 2);
    // from rr_ptr=3 with only ch1 valid: skip 3,0 and wrap to ch1
    i_valid = 4'b0010;
    #1;
    check("wrap_ready", o_ready, 4'b0010);
    tick();
    check("wrap_ch", o_ch, 1);
    check("wrap_cnt", o_xfer_cnt, 7);
    check("wrap_valid", o_valid, 1);
    // rr_ptr now 2: all valid -> ch2 first
    i_valid = 4'b1111;
    #1;
    check("ptr2_ready", o_ready, 4'b0100);

    // reset with a word held and count at 7
    i_reset = 1'b1;
    #1;
    check("midrst_ready", o_ready, 4'b0000);
    tick();
    check("midrst_valid", o_valid, 0);
    check("midrst_data", o_data, 0);
    check("midrst_ch", o_ch, 0);
    check("midrst_cnt", o_xfer_cnt, 0);
    i_reset = 1'b0;
    #1;
    check("restart_ready", o_ready, 4'b0001);
    tick();
    check("restart_ch", o_ch, 0);
    check("restart_data", o_data, 32'hA0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
